// File: rtl/multicycle_addsub_if.sv
// Operand/result handshake bundle for multicycle_addsub.
// Both the input and output channels use valid/ready handshakes.
interface multicycle_addsub_if #(
   parameter int WIDTH = 32
);
   // A channel transfers on a rising clock edge where its valid and ready
   // are both high. valid holds until the transfer happens. ready may be
   // high without valid.
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/multicycle_addsub.sv
// Chunk-serial adder/subtractor: CHUNK bits per cycle, carry held between chunks.
// Optional macro ADDSUB_SAT_EN saturates the result on signed overflow.
module multicycle_addsub #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   multicycle_addsub_if.slave  bus,
   output logic [1:0]          o_dbg_state
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [KW-1:0]    r_k;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic [31:0]      w_base;
   logic [CHUNK:0]   w_chunk;
   logic             w_msb_cin;
   logic             w_ovf;
   logic             w_last;
   logic             w_accept;
   logic [WIDTH-1:0] w_sum_next;

   assign w_base   = 32'(r_k) * 32'(CHUNK);
   assign w_last   = (r_k == K_LAST);
   assign w_accept = (r_state == S_IDLE) && bus.in_valid;

   // One CHUNK-bit ripple slice; bit CHUNK is the slice carry-out.
   assign w_chunk = {1'b0, r_a[w_base +: CHUNK]} + {1'b0, r_b[w_base +: CHUNK]}
                    + {{CHUNK{1'b0}}, r_carry};

   // On the last slice its top bit is the word MSB, so the carry into the MSB
   // is recovered from the MSB sum bit and the two operand bits.
   assign w_msb_cin = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_chunk[CHUNK-1];
   assign w_ovf     = w_msb_cin ^ w_chunk[CHUNK];

   always_comb begin
      w_sum_next = r_sum;
      w_sum_next[w_base +: CHUNK] = w_chunk[CHUNK-1:0];
`ifdef ADDSUB_SAT_EN
      // Overflow implies both effective operands share r_a's sign.
      if (w_last && w_ovf) begin
         w_sum_next = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
      end
`else
      w_sum_next = w_sum_next;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.in_valid)  w_state_next = S_CALC;
         S_CALC:  if (w_last)        w_state_next = S_DONE;
         S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
         default:                    w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (r_state == S_IDLE);
      bus.out_valid = (r_state == S_DONE);
      o_dbg_state   = r_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_k     <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         // Subtract is a + ~b + ~borrow_in.
         r_a     <= bus.a;
         r_b     <= bus.b ^ {WIDTH{bus.sub}};
         r_carry <= bus.cin ^ bus.sub;
         r_k     <= '0;
      end else if (r_state == S_CALC) begin
         r_sum   <= w_sum_next;
         r_carry <= w_chunk[CHUNK];
         r_k     <= r_k + 1'b1;
         if (w_last) begin
            r_cout <= w_chunk[CHUNK];
            r_ovf  <= w_ovf;
         end
      end
   end

   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;
   assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_multicycle_addsub.sv
// Directed bench for multicycle_addsub (WIDTH=32, CHUNK=8).
// Expected values follow ADDSUB_SAT_EN when it is defined.
module tb_multicycle_addsub;
  localparam int WIDTH  = 32;
  localparam int NCHUNK = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_vec;
  int         n_miss;

  multicycle_addsub_if #(.WIDTH(WIDTH)) bus ();

  multicycle_addsub #(.WIDTH(WIDTH), .CHUNK(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub,
                       input logic [31:0] e_sum, input logic e_cout, input logic e_ovf);
    int n;
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_busy_in_ready"}, 32'(bus.in_ready), 32'd0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(NCHUNK));
    check({tag, "_sum"}, bus.sum, e_sum);
    check({tag, "_cout"}, 32'(bus.cout), 32'(e_cout));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(e_ovf));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_idle_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_sum_retained"}, bus.sum, e_sum);
  endtask

  initial begin
    logic [31:0] held_sum;
    int          n;
    n_vec = 0;
    n_miss = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;

    #3;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", bus.sum, 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    #20 rst_n = 1'b1;
    tick();

    do_op("t1_add_ff", 32'h0000_00FF, 32'h1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    do_op("t2_ripple", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    do_op("t3_sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op("t3_sub_bin", 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
    do_op("t3_add_cin", 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
    do_op("t4_pos_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    do_op("t4_neg_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
`else
    do_op("t4_pos_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    do_op("t4_neg_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif

    // Backpressure: hold the result while new operands are offered.
    bus.a = 32'h1234_5678; bus.b = 32'h1111_1111; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check("t5_latency", 32'(n), 32'(NCHUNK));
    check("t5_sum", bus.sum, 32'h2345_6789);
    held_sum = 32'h2345_6789;
    for (int i = 0; i < 5; i++) begin
      bus.a = $urandom_range(32'hFFFF, 0);
      bus.b = $urandom_range(32'hFFFF, 0);
      bus.sub = i[0];
      tick();
      check("t5_hold_sum", bus.sum, held_sum);
      check("t5_hold_valid", 32'(bus.out_valid), 32'd1);
      check("t5_hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("t5_hold_cout", 32'(bus.cout), 32'd0);
      check("t5_hold_ovf", 32'(bus.ovf), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("t5_release_in_ready", 32'(bus.in_ready), 32'd1);
    check("t5_release_valid", 32'(bus.out_valid), 32'd0);
    do_op("t5_next", 32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0, 32'h0000_1234, 1'b0, 1'b0);

    // Reset during the second compute cycle discards the op.
    bus.a = 32'h0101_0101; bus.b = 32'h0101_0101; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("t6_partial_chunk0", bus.sum & 32'hFF, 32'h02);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_sum", bus.sum, 32'd0);
    check("t6_rst_in_ready", 32'(bus.in_ready), 32'd1);
    #2 rst_n = 1'b1;
    tick();
    check("t6_after_rst_valid", 32'(bus.out_valid), 32'd0);
    do_op("t6_after", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
